stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 100000000, meaning clock cycles per count tick (minimum 2).
REQ-002 The block SHALL have parameter UP_LIMIT, default 16'h9999, meaning the 4-digit BCD terminal value for up mode.
REQ-003 The block SHALL have port CLK  input  1  meaning the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port RESET_N  input  1  meaning the reset, which is asynchronous and active-low.
REQ-005 The block SHALL have port START  input  1  meaning a one-cycle pulse that starts, resumes or acknowledges.
REQ-006 The block SHALL have port STOP  input  1  meaning a one-cycle pulse that pauses.
REQ-007 The block SHALL have port CLEAR  input  1  meaning a one-cycle pulse that aborts to idle.
REQ-008 The block SHALL have port DIR  input  1  meaning 0 for up, 1 for down; it is sampled only on START in IDLE.
REQ-009 The block SHALL have port PRESET  input  16  meaning the 4-digit BCD start value for down mode.
REQ-010 The block SHALL have port LAP  input  1  meaning a one-cycle lap-capture pulse.
REQ-011 The block SHALL have port DIGITS  output  16  meaning the current 4-digit BCD count, with digit 0 in [3:0].
REQ-012 The block SHALL have port LAP_DIGITS  output  16  meaning the captured lap value.
REQ-013 The block SHALL have port STATE  output  2  meaning the FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-014 The block SHALL have port DONE_PULSE  output  1  meaning high for exactly one cycle on entry to DONE.

Function
REQ-015 The FSM states and transitions SHALL be:
- IDLE->RUN on START.
- RUN->PAUSE on STOP.
- PAUSE->RUN on START.
- RUN->DONE on the terminal count.
- DONE->IDLE on START.
- any state->IDLE on CLEAR.
REQ-016 Simultaneous pulses SHALL resolve with priority CLEAR > STOP > START, and a lower-priority pulse in the same cycle SHALL be ignored.
REQ-017 A START in IDLE at edge n SHALL give STATE=RUN, the latched DIR, and loaded DIGITS after edge n:
- Up mode loads 16'h0000.
- Down mode loads PRESET, with any nibble greater than 9 clamped to 9.
REQ-018 The prescaler SHALL count 0..TICK_DIV-1 only in RUN, clear to 0 on IDLE->RUN, and hold its value in PAUSE so that a resume continues the partial tick.
REQ-019 A tick SHALL occur in the RUN cycle where the prescaler equals TICK_DIV-1, and DIGITS SHALL update on that same edge (1-cycle latency).
REQ-020 The tick SHALL ripple through the digits as a BCD cascade:
- Up mode: 9->0 with a carry to the next digit.
- Down mode: 0->9 with a borrow from the next digit.
REQ-021 In up mode, a tick that makes DIGITS equal UP_LIMIT SHALL move the FSM to DONE on the same edge.
REQ-022 In down mode, a tick that makes DIGITS equal 16'h0000 SHALL move the FSM to DONE on the same edge.
REQ-023 A down-mode START with a clamped PRESET of 0000 SHALL enter DONE directly, not RUN, after edge n.
REQ-024 An up-mode START with UP_LIMIT=0000 SHALL likewise enter DONE directly after edge n.
REQ-025 DONE_PULSE SHALL assert in the first cycle that STATE=DONE and deassert in the next cycle.
REQ-026 DIGITS SHALL hold in PAUSE and in DONE.
REQ-027 CLEAR SHALL set DIGITS to 0000, the prescaler to 0 and STATE to IDLE after the edge.
REQ-028 STOP in IDLE, PAUSE or DONE, and START in RUN, SHALL have no effect.

Reset
REQ-029 Assertion of RESET_N=0 SHALL, asynchronously and without a clock, set STATE=IDLE, DIGITS=0000, LAP_DIGITS=0000, DONE_PULSE=0, prescaler=0 and DIR latch=0.
REQ-030 Reset asserted mid-count SHALL discard all progress.
REQ-031 After RESET_N deasserts, the block SHALL leave IDLE only on the first clean START.

Configuration
REQ-032 With macro STOPWATCH_CTRL_LAP_EN defined, LAP asserted in RUN SHALL copy DIGITS (the pre-edge value) into LAP_DIGITS on that edge.
REQ-033 With STOPWATCH_CTRL_LAP_EN defined, LAP in any other state SHALL be ignored, and CLEAR SHALL zero LAP_DIGITS.
REQ-034 Without STOPWATCH_CTRL_LAP_EN, LAP SHALL be ignored, LAP_DIGITS SHALL be constant 0000, and no lap register SHALL be synthesised.

Structure
REQ-035 A shared package stopwatch_pkg SHALL hold the state encodings IDLE/RUN/PAUSE/DONE, the BCD_MAX=9 constant and the 4-bit digit width.
REQ-036 One sub-module, bcd_digit, SHALL be instantiated 4 times in a chain.
REQ-037 bcd_digit SHALL provide a 4-bit 0..9 counter with synchronous load, enable, direction and a combinational carry/borrow-out.

Verification (TICK_DIV=4 for simulation)
REQ-038 Up-mode count scenario: DIR=0, START -> DIGITS=0000 after 1 edge, 0001 after 4 more edges, and 0010 at the 10th tick.
REQ-039 Down-mode terminal scenario: PRESET=0002, DIR=1, START -> DIGITS go 0002, 0001, 0000 on successive ticks, then STATE=DONE with DONE_PULSE high one cycle, and START -> IDLE.
REQ-040 Pause/resume scenario: STOP at prescaler=2, hold 20 cycles, then START -> DIGITS unchanged while paused, and the next tick comes 2 cycles after resume.
REQ-041 Priority and clamp scenario: CLEAR, STOP and START in one cycle during RUN -> IDLE with 0000; PRESET=16'h00A0 -> the load gives 0090.
REQ-042 Asynchronous reset scenario: RESET_N low mid-cycle in RUN at 0123 -> outputs reach their reset values before the next CLK edge.
REQ-043 Lap scenario, with STOPWATCH_CTRL_LAP_EN defined: LAP at DIGITS=0005 -> LAP_DIGITS=0005 while counting continues.
REQ-044 Lap scenario, without STOPWATCH_CTRL_LAP_EN: LAP at DIGITS=0005 -> LAP_DIGITS stays 0000.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: FSM state encoding,
// BCD digit width and the per-nibble preset clamp.
package stopwatch_pkg;

  localparam int          DIGIT_W = 4;
  localparam int          NUM_DIG = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Any nibble above 9 is forced to 9 so the counter never holds a non-BCD digit.
  function automatic logic [15:0] clamp_bcd(input logic [15:0] raw);
    logic [15:0] res;
    res = 16'h0000;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (raw[i*DIGIT_W +: DIGIT_W] > BCD_MAX) begin
        res[i*DIGIT_W +: DIGIT_W] = BCD_MAX;
      end else begin
        res[i*DIGIT_W +: DIGIT_W] = raw[i*DIGIT_W +: DIGIT_W];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One BCD digit (0..9) of the stopwatch count: synchronous clear/load,
// enable, up/down direction and a combinational carry/borrow-out.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               en,
  input  logic               dir,
  output logic [DIGIT_W-1:0] value,
  output logic [DIGIT_W-1:0] value_next,
  output logic               co
);

  logic [DIGIT_W-1:0] value_q;
  logic [DIGIT_W-1:0] value_d;

  // Stepped value and wrap carry/borrow; value_next lets the parent see the post-tick count.
  always_comb begin
    value_next = value_q;
    co         = 1'b0;
    if (en) begin
      if (dir) begin
        co = (value_q == 4'd0);
        if (value_q == 4'd0) begin
          value_next = BCD_MAX;
        end else begin
          value_next = value_q - 4'd1;
        end
      end else begin
        co = (value_q == BCD_MAX);
        if (value_q == BCD_MAX) begin
          value_next = 4'd0;
        end else begin
          value_next = value_q + 4'd1;
        end
      end
    end else begin
      value_next = value_q;
    end
  end

  always_comb begin
    value_d = value_next;
    if (clr) begin
      value_d = 4'd0;
    end else if (load) begin
      value_d = load_val;
    end else begin
      value_d = value_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= 4'd0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Four-digit BCD up/down stopwatch with pause and terminal-count detection.
// Optional lap capture register is built only when STOPWATCH_CTRL_LAP_EN is defined.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int          TICK_DIV = 100000000,
  parameter logic [15:0] UP_LIMIT = 16'h9999
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic        STOP,
  input  logic        CLEAR,
  input  logic        DIR,
  input  logic [15:0] PRESET,
  input  logic        LAP,
  output logic [15:0] DIGITS,
  output logic [15:0] LAP_DIGITS,
  output logic [1:0]  STATE,
  output logic        DONE_PULSE
);

  localparam int             PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          dir_q, dir_d;
  logic          done_pulse_q, done_pulse_d;

  logic          stop_s, start_s, load_s, run_s, tick_s, term_s;
  logic [15:0]   load_val_s, digits_s, digits_next_s, target_s;
  logic [NUM_DIG:0] carry_s;

  // Lower-priority pulses are masked by any higher-priority one in the same cycle.
  assign stop_s     = STOP & ~CLEAR;
  assign start_s    = START & ~STOP & ~CLEAR;
  assign load_val_s = DIR ? clamp_bcd(PRESET) : 16'h0000;
  assign load_s     = start_s && (state_q == IDLE);
  assign run_s      = (state_q == RUN) && !CLEAR && !STOP;
  assign tick_s     = run_s && (presc_q == PRESC_LAST);
  assign target_s   = dir_q ? 16'h0000 : UP_LIMIT;
  // A carry out of the top digit can only happen with an unreachable limit; treat it as terminal.
  assign term_s     = tick_s && ((digits_next_s == target_s) || carry_s[NUM_DIG]);
  assign carry_s[0] = tick_s;

  for (genvar i = 0; i < NUM_DIG; i++) begin : g_digit
    bcd_digit u_digit (
      .clk        (CLK),
      .rst_n      (RESET_N),
      .clr        (CLEAR),
      .load       (load_s),
      .load_val   (load_val_s[i*DIGIT_W +: DIGIT_W]),
      .en         (carry_s[i]),
      .dir        (dir_q),
      .value      (digits_s[i*DIGIT_W +: DIGIT_W]),
      .value_next (digits_next_s[i*DIGIT_W +: DIGIT_W]),
      .co         (carry_s[i+1])
    );
  end

  // Next-state, prescaler and direction latch.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    dir_d   = dir_q;
    if (CLEAR) begin
      state_d = IDLE;
      presc_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_s) begin
            dir_d   = DIR;
            presc_d = '0;
            if (load_val_s == (DIR ? 16'h0000 : UP_LIMIT)) begin
              state_d = DONE;
            end else begin
              state_d = RUN;
            end
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (stop_s) begin
            state_d = PAUSE;
          end else if (tick_s) begin
            presc_d = '0;
            if (term_s) begin
              state_d = DONE;
            end else begin
              state_d = RUN;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        PAUSE: begin
          if (start_s) begin
            state_d = RUN;
          end else begin
            state_d = PAUSE;
          end
        end
        DONE: begin
          if (start_s) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          state_d = IDLE;
          presc_d = '0;
        end
      endcase
    end
    done_pulse_d = (state_d == DONE) && (state_q != DONE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      dir_q        <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      dir_q        <= dir_d;
      done_pulse_q <= done_pulse_d;
    end
  end

`ifdef STOPWATCH_CTRL_LAP_EN
  logic [15:0] lap_q, lap_d;

  // Lap snapshot takes the count as it stood before this edge.
  always_comb begin
    lap_d = lap_q;
    if (CLEAR) begin
      lap_d = 16'h0000;
    end else if ((state_q == RUN) && LAP) begin
      lap_d = digits_s;
    end else begin
      lap_d = lap_q;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      lap_q <= 16'h0000;
    end else begin
      lap_q <= lap_d;
    end
  end

  assign LAP_DIGITS = lap_q;
`else
  logic lap_unused_s;
  assign lap_unused_s = LAP;
  assign LAP_DIGITS   = 16'h0000;
`endif

  assign DIGITS     = digits_s;
  assign STATE      = state_q;
  assign DONE_PULSE = done_pulse_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus random pulses
// against a decimal-integer reference model of the stopwatch.
module tb_stopwatch_ctrl;

  localparam int          TICK_DIV = 4;
  localparam logic [15:0] UP_LIM   = 16'h0015;
`ifdef STOPWATCH_CTRL_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET_N, START, STOP, CLEAR, DIR, LAP;
  logic [15:0] PRESET;
  logic [15:0] DIGITS, LAP_DIGITS;
  logic [1:0]  STATE;
  logic        DONE_PULSE;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: count held as a plain decimal integer
  int m_state, m_cnt, m_presc, m_lap, m_lim;
  bit m_dir, m_pulse;

  stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .UP_LIMIT(UP_LIM)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .STOP(STOP), .CLEAR(CLEAR),
    .DIR(DIR), .PRESET(PRESET), .LAP(LAP), .DIGITS(DIGITS),
    .LAP_DIGITS(LAP_DIGITS), .STATE(STATE), .DONE_PULSE(DONE_PULSE)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int bcd2int_clamped(input logic [15:0] b);
    int v;
    int d;
    v = 0;
    for (int i = 3; i >= 0; i--) begin
      d = int'(b[i*4 +: 4]);
      if (d > 9) d = 9;
      v = v * 10 + d;
    end
    return v;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_presc = 0; m_lap = 0; m_dir = 1'b0; m_pulse = 1'b0;
  endtask

  task automatic model_step(input bit st, input bit sp, input bit cl, input bit lp,
                            input bit dr, input logic [15:0] pr);
    int prev;
    int target;
    prev = m_state;
    if (cl) begin
      m_state = 0; m_cnt = 0; m_presc = 0; m_lap = 0;
    end else begin
      if (LAP_EN && lp && m_state == 1) m_lap = m_cnt;
      if (m_state == 1 && sp) begin
        m_state = 2;
      end else if (m_state == 0) begin
        if (st && !sp) begin
          m_dir   = dr;
          m_cnt   = dr ? bcd2int_clamped(pr) : 0;
          m_presc = 0;
          m_state = (m_cnt == (dr ? 0 : m_lim)) ? 3 : 1;
        end
      end else if (m_state == 2) begin
        if (st && !sp) m_state = 1;
      end else if (m_state == 3) begin
        if (st && !sp) m_state = 0;
      end else begin
        target = m_dir ? 0 : m_lim;
        if (m_presc == TICK_DIV - 1) begin
          m_presc = 0;
          m_cnt   = m_dir ? m_cnt - 1 : (m_cnt + 1) % 10000;
          if (m_cnt == target) m_state = 3;
        end else begin
          m_presc++;
        end
      end
    end
    m_pulse = (m_state == 3) && (prev != 3);
  endtask

  task automatic check_outputs();
    check_eq("digits", 32'(DIGITS), 32'(int2bcd(m_cnt)));
    check_eq("state", 32'(STATE), 32'(m_state));
    check_eq("done_pulse", 32'(DONE_PULSE), 32'(m_pulse));
    check_eq("lap_digits", 32'(LAP_DIGITS), 32'(int2bcd(m_lap)));
  endtask

  // Drive one cycle of inputs (called at a falling edge), advance the model, check after the edge.
  task automatic do_cycle(input bit st, input bit sp, input bit cl, input bit lp,
                          input bit dr, input logic [15:0] pr);
    START = st; STOP = sp; CLEAR = cl; LAP = lp; DIR = dr; PRESET = pr;
    model_step(st, sp, cl, lp, dr, pr);
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    m_lim = bcd2int_clamped(UP_LIM);
    RESET_N = 1'b0; START = 1'b0; STOP = 1'b0; CLEAR = 1'b0;
    DIR = 1'b0; LAP = 1'b0; PRESET = 16'h0000;
    model_reset();
    repeat (2) @(negedge CLK);
    check_outputs();
    RESET_N = 1'b1;

    // Stray STOP before any START keeps IDLE
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    check_eq("idle_after_stop", 32'(STATE), 32'd0);

    // Up count
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    check_eq("up_load", 32'(DIGITS), 32'h0000);
    check_eq("up_run", 32'(STATE), 32'd1);
    idle_cycles(4);
    check_eq("up_first_tick", 32'(DIGITS), 32'h0001);
    idle_cycles(36);
    check_eq("up_tenth_tick", 32'(DIGITS), 32'h0010);
    idle_cycles(20);
    check_eq("up_limit_digits", 32'(DIGITS), 32'(UP_LIM));
    check_eq("up_limit_done", 32'(STATE), 32'd3);
    check_eq("up_limit_pulse", 32'(DONE_PULSE), 32'd1);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);

    // Down count to terminal
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0002);
    check_eq("dn_load", 32'(DIGITS), 32'h0002);
    idle_cycles(4);
    check_eq("dn_1", 32'(DIGITS), 32'h0001);
    idle_cycles(4);
    check_eq("dn_0", 32'(DIGITS), 32'h0000);
    check_eq("dn_done", 32'(STATE), 32'd3);
    check_eq("dn_pulse_hi", 32'(DONE_PULSE), 32'd1);
    idle_cycles(1);
    check_eq("dn_pulse_lo", 32'(DONE_PULSE), 32'd0);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    check_eq("dn_ack_idle", 32'(STATE), 32'd0);

    // Pause with partial tick, then resume
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    idle_cycles(2);
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    idle_cycles(20);
    check_eq("pause_hold", 32'(DIGITS), 32'h0000);
    check_eq("pause_state", 32'(STATE), 32'd2);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    idle_cycles(1);
    check_eq("resume_no_tick", 32'(DIGITS), 32'h0000);
    idle_cycles(1);
    check_eq("resume_tick", 32'(DIGITS), 32'h0001);

    // All three pulses together: CLEAR wins
    do_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_eq("prio_state", 32'(STATE), 32'd0);
    check_eq("prio_digits", 32'(DIGITS), 32'h0000);

    // Preset clamp, and clamped-zero preset going straight to DONE
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00A0);
    check_eq("clamp", 32'(DIGITS), 32'h0090);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    check_eq("zero_preset_done", 32'(STATE), 32'd3);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);

    // Lap capture while counting continues
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    idle_cycles(20);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    check_eq("lap_value", 32'(LAP_DIGITS), LAP_EN ? 32'h0005 : 32'h0000);
    idle_cycles(3);
    check_eq("lap_keeps_counting", 32'(DIGITS), 32'h0006);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);

    // Asynchronous reset mid-count at 0123
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0125);
    idle_cycles(8);
    check_eq("pre_reset_digits", 32'(DIGITS), 32'h0123);
    START = 1'b0; STOP = 1'b0; CLEAR = 1'b0; LAP = 1'b0;
    #2 RESET_N = 1'b0;
    #1;
    model_reset();
    check_eq("async_digits", 32'(DIGITS), 32'h0000);
    check_eq("async_state", 32'(STATE), 32'd0);
    check_eq("async_pulse", 32'(DONE_PULSE), 32'd0);
    check_eq("async_lap", 32'(LAP_DIGITS), 32'h0000);
    @(negedge CLK);
    RESET_N = 1'b1;
    idle_cycles(3);

    // Random pulses against the model
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] pr;
      pr = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {12'h000, 4'($urandom)};
      do_cycle($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
               $urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
               1'($urandom), pr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
